// File: rtl/i2c_mailbox_target.sv
// i2c_mailbox_target: I2C target at one 7-bit address that pushes written bytes into a FIFO and pops them on reads
module i2c_mailbox_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int DEPTH = 16,
  parameter logic [7:0] EMPTY_BYTE = 8'hFF
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda,
  output logic [$clog2(DEPTH):0] count,
  output logic empty,
  output logic full,
  output logic ovf,
  output logic udf,
  output logic wr_evt,
  output logic rd_evt,
  output logic busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP} state_t;
  state_t state, state_n;
  logic [2:0] scl_q, sda_q, cnt, cnt_n;
  logic [7:0] sh, sh_n, rd_byte, byte_in;
  logic phase, phase_n, oe, oe_n, ack, ack_n;
  logic push, pop, set_ovf, set_udf;
  logic rise, fall, start, stop;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign sda = oe ? 1'b0 : 1'bz;
  assign rise = scl_q[1] & ~scl_q[2];
  assign fall = ~scl_q[1] & scl_q[2];
  assign start = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
  assign byte_in = {sh[6:0], sda_q[1]};
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign rd_byte = empty ? EMPTY_BYTE : mem[rp];
  assign busy = !(state inside {IDLE, ADDR, WAIT_STOP});
  // two-flop synchronizers plus one history stage for edge and START/STOP detection
  always_ff @(posedge clk) begin
    scl_q <= rst ? 3'b111 : {scl_q[1:0], scl};
    sda_q <= rst ? 3'b111 : {sda_q[1:0], sda};
  end
  // protocol state and shifter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      phase <= 1'b0;
      oe <= 1'b0;
      ack <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
      phase <= phase_n;
      oe <= oe_n;
      ack <= ack_n;
    end
  end
  // bus protocol: START/STOP win over bit processing; phase marks the first vs second fall of ACK and first bit of a read
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    phase_n = phase;
    oe_n = oe;
    ack_n = ack;
    push = 1'b0;
    pop = 1'b0;
    set_ovf = 1'b0;
    set_udf = 1'b0;
    if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
    end else if (start) begin
      state_n = ADDR;
      cnt_n = '0;
      oe_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (rise) begin
          sh_n = byte_in;
          cnt_n = cnt + 3'd1;
          phase_n = 1'b0;
          if (cnt == 3'd7) state_n = byte_in[7:1] == SLAVE_ADDR ? ADDR_ACK : WAIT_STOP;
        end
        ADDR_ACK: if (fall) begin
          if (!phase) begin
            oe_n = 1'b1;
            phase_n = 1'b1;
          end else begin
            cnt_n = '0;
            state_n = sh[0] ? RD_DATA : WR_DATA;
            sh_n = sh[0] ? rd_byte : sh;
            set_udf = sh[0] & empty;
            oe_n = sh[0] & ~rd_byte[7];
          end
        end
        WR_DATA: if (rise) begin
          sh_n = byte_in;
          cnt_n = cnt + 3'd1;
          if (cnt == 3'd7) begin
            push = !full;
            set_ovf = full;
            ack_n = !full;
            phase_n = 1'b0;
            state_n = WR_ACK;
          end
        end
        WR_ACK: if (fall) begin
          if (!phase) begin
            oe_n = ack;
            phase_n = 1'b1;
          end else begin
            oe_n = 1'b0;
            cnt_n = '0;
            state_n = ack ? WR_DATA : WAIT_STOP;
          end
        end
        RD_DATA: if (fall) begin
          if (!phase) begin
            oe_n = ~sh[7];
            phase_n = 1'b1;
          end else if (cnt == 3'd7) begin
            oe_n = 1'b0;
            pop = !empty;
            state_n = RD_ACK;
          end else begin
            sh_n = {sh[6:0], 1'b0};
            oe_n = ~sh[6];
            cnt_n = cnt + 3'd1;
          end
        end
        RD_ACK: if (rise) begin
          state_n = sda_q[1] ? WAIT_STOP : RD_DATA;
          sh_n = sda_q[1] ? sh : rd_byte;
          set_udf = !sda_q[1] & empty;
          cnt_n = '0;
          phase_n = 1'b0;
        end
        default: ;
      endcase
    end
  end
  // FIFO pointers, occupancy, sticky flags and event pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
      wr_evt <= 1'b0;
      rd_evt <= 1'b0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      count <= push ? count + 1'b1 : pop ? count - 1'b1 : count;
      ovf <= ovf | set_ovf;
      udf <= udf | set_udf;
      wr_evt <= push;
      rd_evt <= pop;
    end
  end
  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= byte_in;
  end
endmodule

// File: tb/tb_i2c_mailbox_target.sv
// tb_i2c_mailbox_target: directed bit-banged I2C master exercising the mailbox target
module tb_i2c_mailbox_target;
  localparam int Q = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic m_oe = 1'b0;
  wire sda;
  logic [4:0] count;
  logic empty, full, ovf, udf, wr_evt, rd_evt, busy;
  int vecs = 0;
  int errs = 0;
  int wr_n = 0;
  int rd_n = 0;
  int busy_n = 0;
  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);
  always #5 clk = ~clk;
  i2c_mailbox_target dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .count(count), .empty(empty), .full(full),
    .ovf(ovf), .udf(udf), .wr_evt(wr_evt), .rd_evt(rd_evt), .busy(busy)
  );
  // event tallies, sampled on the falling clk edge
  always @(negedge clk) begin
    if (wr_evt) wr_n++;
    if (rd_evt) rd_n++;
    if (busy) busy_n++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start();
    m_oe = 1'b0; wq(Q);
    scl = 1'b1; wq(2*Q);
    m_oe = 1'b1; wq(2*Q);
    scl = 1'b0; wq(Q);
  endtask
  task automatic i2c_stop();
    m_oe = 1'b1; wq(Q);
    scl = 1'b1; wq(2*Q);
    m_oe = 1'b0; wq(2*Q);
  endtask
  task automatic write_bit(input logic b);
    wq(Q); m_oe = ~b; wq(Q);
    scl = 1'b1; wq(2*Q);
    scl = 1'b0;
  endtask
  task automatic read_bit(output logic b);
    m_oe = 1'b0; wq(2*Q);
    scl = 1'b1; wq(Q);
    b = (sda !== 1'b0); wq(Q);
    scl = 1'b0;
  endtask
  task automatic write_byte(input logic [7:0] d, output logic nak);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(nak);
  endtask
  task automatic read_byte(input logic nak, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nak);
  endtask
  initial begin
    logic a, a2;
    logic [7:0] d;
    int w0, r0, b0, nacks;
    wq(4);
    rst = 1'b0;
    wq(2);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_flags", {ovf, udf, wr_evt, rd_evt, busy}, 0);
    chk("rst_sda", sda, 1);
    w0 = wr_n; b0 = busy_n;
    i2c_start();
    write_byte(8'hA0, a); chk("wr_addr_ack", a, 0);
    write_byte(8'hA5, a); chk("wr_data_ack", a, 0);
    chk("wr_busy", busy, 1);
    i2c_stop();
    chk("wr_count", count, 1);
    chk("wr_evt_pulses", wr_n - w0, 1);
    chk("busy_after_stop", busy, 0);
    r0 = rd_n;
    i2c_start();
    write_byte(8'hA1, a); chk("rd_addr_ack", a, 0);
    read_byte(1'b1, d); chk("rd_dout", d, 8'hA5);
    i2c_stop();
    chk("rd_count", count, 0);
    chk("rd_empty", empty, 1);
    chk("rd_evt_pulses", rd_n - r0, 1);
    chk("rd_udf", udf, 0);
    b0 = busy_n;
    i2c_start();
    write_byte(8'hA2, a); chk("bad_addr_nack", a, 1);
    write_byte(8'h3C, a); chk("bad_data_nack", a, 1);
    i2c_stop();
    chk("bad_count", count, 0);
    chk("bad_busy_never", busy_n - b0, 0);
    w0 = wr_n; nacks = 0;
    i2c_start();
    write_byte(8'hA0, a); chk("fill_addr_ack", a, 0);
    for (int i = 0; i < 16; i++) begin
      write_byte(8'(i), a);
      nacks += int'(a);
    end
    chk("fill_nacks", nacks, 0);
    chk("fill_full", full, 1);
    write_byte(8'h99, a); chk("ovf_nack", a, 1);
    i2c_stop();
    chk("ovf_flag", ovf, 1);
    chk("ovf_count", count, 16);
    chk("fill_wr_evts", wr_n - w0, 16);
    r0 = rd_n;
    i2c_start();
    write_byte(8'hA1, a); chk("drain_addr_ack", a, 0);
    for (int i = 0; i < 16; i++) begin
      read_byte(i == 15, d);
      chk($sformatf("drain_%0d", i), d, i);
    end
    i2c_stop();
    chk("drain_count", count, 0);
    chk("drain_empty", empty, 1);
    chk("drain_rd_evts", rd_n - r0, 16);
    chk("drain_udf", udf, 0);
    r0 = rd_n;
    i2c_start();
    write_byte(8'hA1, a); chk("udf_addr_ack", a, 0);
    read_byte(1'b1, d); chk("udf_dout", d, 8'hFF);
    i2c_stop();
    chk("udf_flag", udf, 1);
    chk("udf_count", count, 0);
    chk("udf_no_rd_evt", rd_n - r0, 0);
    i2c_start();
    write_byte(8'hA0, a); chk("mid_addr_ack", a, 0);
    for (int i = 7; i >= 0; i--) write_bit(a5_bit(i));
    m_oe = 1'b0; wq(2*Q);
    chk("mid_ack_driven", sda, 0);
    chk("mid_count_pre", count, 1);
    rst = 1'b1;
    wq(1);
    chk("mid_rst_release", sda, 1);
    chk("mid_rst_count", count, 0);
    rst = 1'b0;
    wq(2);
    i2c_start();
    write_byte(8'hA0, a); chk("abort_addr_ack", a, 0);
    for (int i = 0; i < 4; i++) write_bit(1'b0);
    i2c_start();
    write_byte(8'hA0, a);
    write_byte(8'h5A, a2);
    chk("restart_acks", {a, a2}, 0);
    i2c_stop();
    chk("restart_count", count, 1);
    i2c_start();
    write_byte(8'hA1, a);
    read_byte(1'b1, d); chk("restart_dout", d, 8'h5A);
    i2c_stop();
    chk("restart_count_end", count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  function automatic logic a5_bit(input int i);
    logic [7:0] v;
    v = 8'hA5;
    return v[i];
  endfunction
endmodule
